next_kbd_responder: RTL



---
 rtl/next_kbd_responder.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/next_kbd_responder.sv
// Device end of the NeXT keyboard serial link: decodes host reset/query frames
// and answers with ready or data frames fed from keyboard and mouse holding registers.
module next_kbd_responder #(
    parameter int BIT_CLKS = 27,
    parameter int HALF_BIT = 13,
    parameter int RESP_GAP = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        from_host,
    output logic        to_host,
    input  logic        kb_valid,
    input  logic [15:0] kb_data,
    output logic        kb_ready,
    input  logic        ms_valid,
    input  logic [15:0] ms_data,
    output logic        ms_ready,
    output logic        host_reset_seen,
    output logic        frame_err
);

    localparam int GAP_CLKS = RESP_GAP * BIT_CLKS;
    localparam int CNT_MAX  = (GAP_CLKS > BIT_CLKS) ? GAP_CLKS : BIT_CLKS;
    localparam int CW       = $clog2(CNT_MAX + 1);

    localparam logic [7:0]  KB_QUERY    = 8'b00001000;
    localparam logic [7:0]  MS_QUERY    = 8'b10001000;
    localparam logic [7:0]  RST_PREFIX  = 8'b11110111;
    localparam logic [20:0] RST_FRAME   = 21'b111101111110000000000;
    localparam logic [20:0] READY_FRAME = 21'b111000000001100000000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_START,
        S_RX_BITS,
        S_GAP,
        S_TX
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [4:0]    rx_bits, rx_bits_n;
    logic [4:0]    tx_bits, tx_bits_n;
    logic [20:0]   rx_sr, rx_sr_n;
    logic [20:0]   tx_sr, tx_sr_n;
    logic          to_host_n;
    logic          frame_err_n;
    logic          sel_ms, sel_ms_n;
    logic          rel_kb_pend, rel_kb_pend_n;
    logic          rel_ms_pend, rel_ms_pend_n;
    logic [1:0]    sync;
    logic          line, line_q, line_fall;

    logic          set_seen, clr_regs, rel_kb, rel_ms;
    logic [20:0]   rx_shift;
    logic          bit_end;
    logic [15:0]   word;
    logic          word_full;

    logic          kb_full, ms_full;
    logic [15:0]   kb_word, ms_word;

    assign kb_ready = ~kb_full;
    assign ms_ready = ~ms_full;

    // A frame that ends on a 0 must not re-arm the receiver: start bits are
    // recognised only on a high-to-low transition of the synchronised line.
    assign line      = sync[1];
    assign line_fall = line_q & ~line;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            rx_bits     <= '0;
            tx_bits     <= '0;
            rx_sr       <= '0;
            tx_sr       <= '0;
            to_host     <= 1'b1;
            frame_err   <= 1'b0;
            sel_ms      <= 1'b0;
            rel_kb_pend <= 1'b0;
            rel_ms_pend <= 1'b0;
            sync        <= '1;
            line_q      <= 1'b1;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            rx_bits     <= rx_bits_n;
            tx_bits     <= tx_bits_n;
            rx_sr       <= rx_sr_n;
            tx_sr       <= tx_sr_n;
            to_host     <= to_host_n;
            frame_err   <= frame_err_n;
            sel_ms      <= sel_ms_n;
            rel_kb_pend <= rel_kb_pend_n;
            rel_ms_pend <= rel_ms_pend_n;
            sync        <= {sync[0], from_host};
            line_q      <= line;
        end
    end

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        rx_bits_n     = rx_bits;
        tx_bits_n     = tx_bits;
        rx_sr_n       = rx_sr;
        tx_sr_n       = tx_sr;
        to_host_n     = to_host;
        frame_err_n   = 1'b0;
        sel_ms_n      = sel_ms;
        rel_kb_pend_n = rel_kb_pend;
        rel_ms_pend_n = rel_ms_pend;
        set_seen      = 1'b0;
        clr_regs      = 1'b0;
        rel_kb        = 1'b0;
        rel_ms        = 1'b0;
        rx_shift      = {rx_sr[19:0], line};
        bit_end       = (cnt == CW'(BIT_CLKS - 1));
        word          = sel_ms ? ms_word : kb_word;
        word_full     = sel_ms ? ms_full : kb_full;

        case (state)
            S_IDLE: begin
                to_host_n = 1'b1;
                if (line_fall) begin
                    state_n = S_RX_START;
                    cnt_n   = '0;
                end
            end

            S_RX_START: begin
                cnt_n = cnt + CW'(1);
                if (cnt == CW'(HALF_BIT - 1)) begin
                    cnt_n = '0;
                    if (line) begin
                        frame_err_n = 1'b1;
                        state_n     = S_IDLE;
                    end else begin
                        state_n   = S_RX_BITS;
                        rx_bits_n = '0;
                        rx_sr_n   = '0;
                    end
                end
            end

            S_RX_BITS: begin
                cnt_n = cnt + CW'(1);
                if (bit_end) begin
                    cnt_n     = '0;
                    rx_sr_n   = rx_shift;
                    rx_bits_n = rx_bits + 5'd1;
                    if (rx_bits == 5'd7) begin
                        if (rx_shift[7:0] == KB_QUERY) begin
                            state_n  = S_GAP;
                            sel_ms_n = 1'b0;
                        end else if (rx_shift[7:0] == MS_QUERY) begin
                            state_n  = S_GAP;
                            sel_ms_n = 1'b1;
                        end else if (rx_shift[7:0] != RST_PREFIX) begin
                            frame_err_n = 1'b1;
                            state_n     = S_IDLE;
                        end
                    end else if (rx_bits == 5'd20) begin
                        if (rx_shift == RST_FRAME) begin
                            set_seen = 1'b1;
                            clr_regs = 1'b1;
                        end else begin
                            frame_err_n = 1'b1;
                        end
                        state_n = S_IDLE;
                    end
                end
            end

            S_GAP: begin
                cnt_n = cnt + CW'(1);
                if (cnt == CW'(GAP_CLKS - 1)) begin
                    cnt_n = '0;
                    if (!host_reset_seen) begin
                        state_n = S_IDLE;
                    end else begin
                        state_n       = S_TX;
                        to_host_n     = 1'b0;
                        tx_bits_n     = '0;
                        rel_kb_pend_n = ~sel_ms & kb_full;
                        rel_ms_pend_n = sel_ms & ms_full;
                        if (word_full)
                            tx_sr_n = {1'b1, 1'b0, word[15:8], 1'b0, 1'b1, word[7:0], 1'b0};
                        else
                            tx_sr_n = READY_FRAME;
                    end
                end
            end

            S_TX: begin
                cnt_n = cnt + CW'(1);
                if (bit_end) begin
                    cnt_n = '0;
                    if (tx_bits == 5'd21) begin
                        to_host_n = 1'b1;
                        state_n   = S_IDLE;
                        rel_kb    = rel_kb_pend;
                        rel_ms    = rel_ms_pend;
                    end else begin
                        to_host_n = tx_sr[0];
                        tx_sr_n   = {1'b0, tx_sr[20:1]};
                        tx_bits_n = tx_bits + 5'd1;
                    end
                end
            end

            default: begin
                state_n   = S_IDLE;
                to_host_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_reset_seen <= 1'b0;
            kb_full         <= 1'b0;
            ms_full         <= 1'b0;
            kb_word         <= '0;
            ms_word         <= '0;
        end else begin
            if (set_seen)
                host_reset_seen <= 1'b1;

            if (clr_regs || rel_kb) begin
                kb_full <= 1'b0;
            end else if (kb_valid && !kb_full) begin
                kb_full <= 1'b1;
                kb_word <= kb_data;
            end

            if (clr_regs || rel_ms) begin
                ms_full <= 1'b0;
            end else if (ms_valid && !ms_full) begin
                ms_full <= 1'b1;
                ms_word <= ms_data;
            end
        end
    end

endmodule
